cpu_run_controller: RTL and testbench



---
 rtl/cpu_run_controller.sv | 131 +++++++++++++
 tb/tb_cpu_run_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle CPU bench: streams a program image into memory,
// runs the CPU out of reset, ends on end-PC / jump-to-self / timeout, and keeps a short trace.
module cpu_run_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 2048,
    parameter int HALT_REPEAT    = 2,
    parameter int TRACE_DEPTH    = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  load_valid,
    output logic                                  load_ready,
    input  logic [ADDR_WIDTH-1:0]                 load_addr,
    input  logic [DATA_WIDTH-1:0]                 load_data,
    input  logic                                  load_last,
    output logic                                  mem_we,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    output logic                                  cpu_reset,
    input  logic [ADDR_WIDTH-1:0]                 pc,
    input  logic [DATA_WIDTH-1:0]                 instruction,
    input  logic [ADDR_WIDTH-1:0]                 end_pc,
    output logic                                  done,
    output logic                                  halted,
    output logic                                  timed_out,
    output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]   cycle_count,
    output logic [$clog2(TRACE_DEPTH+1)-1:0]      trace_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0]        trace_rd_idx,
    output logic [ADDR_WIDTH-1:0]                 trace_pc,
    output logic [DATA_WIDTH-1:0]                 trace_instr
);
    localparam int CW = $clog2(TIMEOUT_CYCLES+1);
    localparam int TW = $clog2(TRACE_DEPTH+1);
    localparam int IW = $clog2(TRACE_DEPTH);
    localparam int RW = $clog2(HALT_REPEAT+1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] DEPTH_VAL   = TW'(TRACE_DEPTH);
    localparam logic [RW-1:0] REPEAT_VAL  = RW'(HALT_REPEAT);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] prev_pc;
    logic                  prev_valid;
    logic [RW-1:0]         rep_cnt;
    logic [ADDR_WIDTH-1:0] trace_pc_mem    [TRACE_DEPTH];
    logic [DATA_WIDTH-1:0] trace_instr_mem [TRACE_DEPTH];

    logic          accept;
    logic          pc_repeat;
    logic          repeat_hit;
    logic          halt_hit;
    logic          timeout_hit;
    logic          trace_space;
    logic [CW-1:0] cnt_next;
    logic [RW-1:0] rep_next;

    assign accept      = (state == LOAD) && load_valid;
    assign load_ready  = (state == LOAD);
    assign done        = (state == DONE);
    assign mem_we      = accept;
    assign mem_addr    = (state == LOAD) ? load_addr : '0;
    assign mem_wdata   = (state == LOAD) ? load_data : '0;

    // The first RUN cycle has no previous pc, so it can never count as a repeat.
    assign pc_repeat   = prev_valid && (pc == prev_pc);
    assign rep_next    = rep_cnt + 1'b1;
    assign repeat_hit  = pc_repeat && (rep_next == REPEAT_VAL);
    assign halt_hit    = (pc == end_pc) || repeat_hit;
    assign cnt_next    = cycle_count + 1'b1;
    assign timeout_hit = (cnt_next == TIMEOUT_VAL);
    assign trace_space = (trace_count < DEPTH_VAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cpu_reset   <= 1'b1;
            halted      <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
            trace_count <= '0;
            prev_pc     <= '0;
            prev_valid  <= 1'b0;
            rep_cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= LOAD;
                LOAD: begin
                    if (accept && load_last) begin
                        state       <= RUN;
                        cpu_reset   <= 1'b0;
                        halted      <= 1'b0;
                        timed_out   <= 1'b0;
                        cycle_count <= '0;
                        trace_count <= '0;
                        prev_valid  <= 1'b0;
                        rep_cnt     <= '0;
                    end
                end
                RUN: begin
                    cycle_count <= cnt_next;
                    if (trace_space) trace_count <= trace_count + 1'b1;
                    prev_pc    <= pc;
                    prev_valid <= 1'b1;
                    rep_cnt    <= pc_repeat ? rep_next : '0;
                    // Halt wins over a timeout detected in the same cycle.
                    if (halt_hit || timeout_hit) begin
                        state     <= DONE;
                        cpu_reset <= 1'b1;
                        halted    <= halt_hit;
                        timed_out <= !halt_hit;
                    end
                end
                DONE: if (start) state <= LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == RUN) && trace_space) begin
            trace_pc_mem[trace_count[IW-1:0]]    <= pc;
            trace_instr_mem[trace_count[IW-1:0]] <= instruction;
        end
    end

    assign trace_pc    = trace_pc_mem[trace_rd_idx];
    assign trace_instr = trace_instr_mem[trace_rd_idx];

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: stimulus queues expected writes and run results,
// monitors pop them on mem_we and on the rising edge of done.
module tb_cpu_run_controller;
    localparam int TO = 16;

    logic        clk = 0;
    logic        reset = 1;
    logic        start = 0;
    logic        load_valid = 0;
    logic        load_ready;
    logic [31:0] load_addr = 0;
    logic [31:0] load_data = 0;
    logic        load_last = 0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic [31:0] pc = 0;
    logic [31:0] instruction;
    logic [31:0] end_pc = 32'hFFFF_FFF0;
    logic        done;
    logic        halted;
    logic        timed_out;
    logic [4:0]  cycle_count;
    logic [4:0]  trace_count;
    logic [3:0]  trace_rd_idx = 0;
    logic [31:0] trace_pc;
    logic [31:0] trace_instr;

    always #5 clk = ~clk;
    always_comb instruction = pc ^ 32'h0013_0013;

    cpu_run_controller #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO),
        .HALT_REPEAT(2), .TRACE_DEPTH(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .pc(pc), .instruction(instruction), .end_pc(end_pc),
        .done(done), .halted(halted), .timed_out(timed_out),
        .cycle_count(cycle_count), .trace_count(trace_count),
        .trace_rd_idx(trace_rd_idx), .trace_pc(trace_pc), .trace_instr(trace_instr)
    );

    typedef struct packed {
        logic            h;
        logic            t;
        logic [4:0]      cc;
        logic [4:0]      tc;
        logic [2:0]      ntr;
        logic [3:0][31:0] tr;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] wq[$];
    logic [31:0] prog[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we must match the oldest issued valid beat.
    always @(negedge clk) begin
        if (mem_we) begin
            if (wq.size() == 0) begin
                check("unexpected_write", {32'h0, mem_addr}, 64'hDEAD);
            end else begin
                logic [63:0] w;
                w = wq.pop_front();
                check("write_addr", {32'h0, mem_addr}, {32'h0, w[63:32]});
                check("write_data", {32'h0, mem_wdata}, {32'h0, w[31:0]});
            end
        end
    end

    // Run-result monitor: compare flags, counters and trace head on the rise of done.
    logic done_q = 0;
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'h1, 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("halted", {63'h0, halted}, {63'h0, e.h});
                check("timed_out", {63'h0, timed_out}, {63'h0, e.t});
                check("cycle_count", {59'h0, cycle_count}, {59'h0, e.cc});
                check("trace_count", {59'h0, trace_count}, {59'h0, e.tc});
                check("cpu_reset_done", {63'h0, cpu_reset}, 64'h1);
                for (int i = 0; i < int'(e.ntr); i++) begin
                    trace_rd_idx = 4'(i);
                    #1;
                    check("trace_pc", {32'h0, trace_pc}, {32'h0, e.tr[i]});
                    check("trace_instr", {32'h0, trace_instr}, {32'h0, e.tr[i] ^ 32'h0013_0013});
                end
            end
        end
        done_q = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic beat(input logic [31:0] a, input logic v, input logic last, input logic st);
        load_addr  = a;
        load_data  = 32'hD000_0000 | a;
        load_valid = v;
        load_last  = last;
        start      = st;
        check("load_ready", {63'h0, load_ready}, 64'h1);
        check("cpu_reset_load", {63'h0, cpu_reset}, 64'h1);
        if (v) wq.push_back({a, 32'hD000_0000 | a});
        tick();
        load_valid = 0;
        load_last  = 0;
        start      = 0;
    endtask

    task automatic load_n(input int n);
        for (int i = 0; i < n; i++) beat(32'(4 * i), 1'b1, (i == n - 1), 1'b0);
        check("cpu_reset_run", {63'h0, cpu_reset}, 64'h0);
    endtask

    task automatic run_prog();
        int i;
        i = 0;
        while (!done && i < 64) begin
            pc = (i < prog.size()) ? prog[i] : prog[prog.size() - 1];
            tick();
            i++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL run_bound: done not seen within %0d cycles", i);
        end
        pc = 0;
    endtask

    task automatic set_prog(input int n, input int stall_from);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back(32'(4 * ((i < stall_from) ? i : stall_from)));
    endtask

    function automatic exp_t mk(input logic h, input logic t, input int cc, input int tc,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3);
        exp_t e;
        e.h = h; e.t = t; e.cc = 5'(cc); e.tc = 5'(tc); e.ntr = 3'd4;
        e.tr = {a3, a2, a1, a0};
        return e;
    endfunction

    initial begin
        tick();
        tick();
        check("rst_cpu_reset", {63'h0, cpu_reset}, 64'h1);
        check("rst_load_ready", {63'h0, load_ready}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_flags", {62'h0, halted, timed_out}, 64'h0);
        check("rst_counts", {54'h0, cycle_count, trace_count}, 64'h0);
        check("rst_mem", {mem_addr, mem_wdata}, 64'h0);
        reset = 0;

        // load_valid outside LOAD must not write
        load_valid = 1;
        load_addr  = 32'h40;
        tick();
        load_valid = 0;

        // end-PC match after a 4-beat image
        end_pc = 12;
        pulse_start();
        load_n(4);
        set_prog(4, 99);
        sb.push_back(mk(1, 0, 4, 4, 0, 4, 8, 12));
        run_prog();

        // jump-to-self: 0,4,8,8,8
        end_pc = 32'hFFFF_FFF0;
        pulse_start();
        load_n(2);
        set_prog(5, 2);
        sb.push_back(mk(1, 0, 5, 5, 0, 4, 8, 8));
        run_prog();

        // timeout with unreachable end_pc
        pulse_start();
        load_n(1);
        set_prog(16, 99);
        sb.push_back(mk(0, 1, 16, 16, 0, 4, 8, 12));
        run_prog();
        tick();
        check("done_frozen_cc", {59'h0, cycle_count}, 64'd16);

        // halt and timeout on the same cycle; flags must survive LOAD and clear on RUN entry
        end_pc = 60;
        pulse_start();
        check("flag_held_in_load", {63'h0, timed_out}, 64'h1);
        load_n(1);
        check("flag_clr_on_run", {62'h0, timed_out, done}, 64'h0);
        check("cc_clr_on_run", {59'h0, cycle_count}, 64'h0);
        set_prog(16, 99);
        sb.push_back(mk(1, 0, 16, 16, 0, 4, 8, 12));
        run_prog();

        // reset during the third RUN cycle
        end_pc = 32'hFFFF_FFF0;
        pulse_start();
        load_n(1);
        pc = 0; tick();
        pc = 4; tick();
        pc = 8;
        reset = 1;
        tick();
        check("mid_rst_cpu_reset", {63'h0, cpu_reset}, 64'h1);
        check("mid_rst_trace_count", {59'h0, trace_count}, 64'h0);
        check("mid_rst_done", {63'h0, done}, 64'h0);
        check("mid_rst_idle", {63'h0, load_ready}, 64'h0);
        reset = 0;
        pc = 0;
        tick();

        // flow control: valid 1,0,1,0,1(last) with start pulses during LOAD
        end_pc = 4;
        pulse_start();
        beat(32'h100, 1'b1, 1'b0, 1'b0);
        beat(32'h104, 1'b0, 1'b0, 1'b1);
        beat(32'h108, 1'b1, 1'b0, 1'b1);
        beat(32'h10C, 1'b0, 1'b0, 1'b0);
        beat(32'h110, 1'b1, 1'b1, 1'b0);
        check("cpu_reset_run_fc", {63'h0, cpu_reset}, 64'h0);
        prog.delete();
        prog.push_back(0);
        prog.push_back(4);
        begin
            exp_t e;
            e = mk(1, 0, 2, 2, 0, 4, 0, 0);
            e.ntr = 3'd2;
            sb.push_back(e);
        end
        run_prog();

        tick();
        tick();
        check("sb_drained", 64'(sb.size()), 64'h0);
        check("writes_drained", 64'(wq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
